// File: rtl/reset_sequencer_pkg.sv
// Shared types and default timing constants for the board reset sequencer.
// Default cycle counts assume a 50 MHz sysclk.
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      S_POR  = 2'd0,
      S_RUN  = 2'd1,
      S_WARM = 2'd2,
      S_COLD = 2'd3
   } state_e;

   localparam int DEF_NUM_BTN          = 2;
   localparam int DEF_POR_CYCLES       = 65000;
   localparam int DEF_DEBOUNCE_CYCLES  = 500000;
   localparam int DEF_HOLD_CYCLES      = 100000000;
   localparam int DEF_MIN_PULSE_CYCLES = 16;

   // Width of a counter whose largest held value is below `terminal`.
   function automatic int cnt_w(input int terminal);
      return (terminal > 1) ? $clog2(terminal) : 1;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Button and reset signal bundle between the board top level and the sequencer.
// The sequencer connects to the slave side; the board connects to the master side.
interface reset_sequencer_if
   import reset_sequencer_pkg::*;
#(
   parameter int NUM_BTN = DEF_NUM_BTN
) ();

   logic [NUM_BTN-1:0] btn;
   logic [NUM_BTN-1:0] btn_db;
   logic [NUM_BTN-1:0] btn_press;
   logic               cold_reset_;
   logic               warm_reset_;
   logic               por_done;

   modport master (
      output btn,
      input  btn_db,
      input  btn_press,
      input  cold_reset_,
      input  warm_reset_,
      input  por_done
   );

   modport slave (
      input  btn,
      output btn_db,
      output btn_press,
      output cold_reset_,
      output warm_reset_,
      output por_done
   );

endinterface

// File: rtl/reset_sequencer_btn_debounce.sv
// One button: 2-flop synchroniser, stable-level debounce and press-edge pulse.
// btn_db_o is normalised so that 1 always means pressed.
module reset_sequencer_btn_debounce
   import reset_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic sysclk,
   input  logic sysreset_,
   input  logic btn_raw_i,
   output logic btn_db_o,
   output logic btn_press_o
);

   localparam int               CNT_W  = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta_q;
   logic             sync_q;
   logic             db_q,    db_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   always_comb begin
      cnt_d   = cnt_q;
      db_d    = db_q;
      press_d = 1'b0;
      if (sync_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_TC) begin
         db_d    = ~db_q;
         press_d = ~db_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Synchroniser resets to the released level so leaving reset never looks like a press.
   always_ff @(posedge sysclk) begin
      if (!sysreset_) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         db_q    <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         meta_q  <= btn_raw_i ^ BTN_ACTIVE_LOW;
         sync_q  <= meta_q;
         db_q    <= db_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign btn_db_o    = db_q;
   assign btn_press_o = press_q;

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: power-on delay, debounced buttons, cold/warm reset with
// minimum width, and long-press escalation of warm to cold.
//
// state  | meaning
// S_POR  | power-on hold, both resets asserted, presses ignored
// S_RUN  | normal operation, both resets released
// S_WARM | warm reset asserted, waiting for min width and warm button release
// S_COLD | cold and warm asserted, waiting for min width and all buttons released
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int NUM_BTN          = DEF_NUM_BTN,
   parameter bit BTN_ACTIVE_LOW   = 1'b1,
   parameter int POR_CYCLES       = DEF_POR_CYCLES,
   parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES      = DEF_HOLD_CYCLES,
   parameter int MIN_PULSE_CYCLES = DEF_MIN_PULSE_CYCLES
) (
   input  logic             sysclk,
   input  logic             sysreset_,
   reset_sequencer_if.slave bus
);

   localparam int POR_W   = cnt_w(POR_CYCLES);
   localparam int PULSE_W = cnt_w(MIN_PULSE_CYCLES);
   localparam int HOLD_W  = cnt_w(HOLD_CYCLES);

   localparam logic [POR_W-1:0]   POR_TC   = POR_W'(POR_CYCLES - 1);
   localparam logic [PULSE_W-1:0] PULSE_TC = PULSE_W'(MIN_PULSE_CYCLES - 1);
   // The warm button was already debounced-high in the press cycle and the entry
   // cycle, so the hold counter stops two short of HOLD_CYCLES.
   localparam logic [HOLD_W-1:0]  HOLD_TC  = HOLD_W'(HOLD_CYCLES - 2);

   logic [NUM_BTN-1:0] db;
   logic [NUM_BTN-1:0] press;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      reset_sequencer_btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
      ) u_debounce (
         .sysclk      (sysclk),
         .sysreset_   (sysreset_),
         .btn_raw_i   (bus.btn[i]),
         .btn_db_o    (db[i]),
         .btn_press_o (press[i])
      );
   end

   state_e             state_q,    state_d;
   logic [POR_W-1:0]   por_cnt_q,  por_cnt_d;
   logic [PULSE_W-1:0] pulse_q,    pulse_d;
   logic [HOLD_W-1:0]  hold_q,     hold_d;
   logic               cold_q,     cold_d;
   logic               warm_q,     warm_d;
   logic               por_done_q, por_done_d;
   logic               pulse_done;

   always_comb begin
      state_d    = state_q;
      por_cnt_d  = por_cnt_q;
      pulse_d    = pulse_q;
      hold_d     = hold_q;
      pulse_done = (pulse_q == PULSE_TC);

      case (state_q)
         S_POR: begin
            if (por_cnt_q == POR_TC) begin
               state_d = S_RUN;
            end else begin
               por_cnt_d = por_cnt_q + POR_W'(1);
            end
         end
         S_RUN: begin
            if (press[0]) begin
               state_d = S_COLD;
            end else if (press[1]) begin
               state_d = S_WARM;
            end
         end
         S_WARM: begin
            if (press[0] || (db[1] && hold_q == HOLD_TC)) begin
               state_d = S_COLD;
            end else if (pulse_done && !db[1]) begin
               state_d = S_RUN;
            end else begin
               if (!pulse_done) begin
                  pulse_d = pulse_q + PULSE_W'(1);
               end
               if (db[1]) begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
         end
         S_COLD: begin
            if (pulse_done && !db[0] && !db[1]) begin
               state_d = S_RUN;
            end else if (!pulse_done) begin
               pulse_d = pulse_q + PULSE_W'(1);
            end
         end
         default: begin
            state_d = S_POR;
         end
      endcase

      if (state_d != state_q && (state_d == S_WARM || state_d == S_COLD)) begin
         pulse_d = '0;
         hold_d  = '0;
      end

      // Outputs are registered from the next state so they change one edge after the cause.
      cold_d     = !(state_d == S_POR || state_d == S_COLD);
      warm_d     = (state_d == S_RUN);
      por_done_d = por_done_q || (state_d != S_POR);
   end

   always_ff @(posedge sysclk) begin
      if (!sysreset_) begin
         state_q    <= S_POR;
         por_cnt_q  <= '0;
         pulse_q    <= '0;
         hold_q     <= '0;
         cold_q     <= 1'b0;
         warm_q     <= 1'b0;
         por_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         por_cnt_q  <= por_cnt_d;
         pulse_q    <= pulse_d;
         hold_q     <= hold_d;
         cold_q     <= cold_d;
         warm_q     <= warm_d;
         por_done_q <= por_done_d;
      end
   end

   assign bus.btn_db      = db;
   assign bus.btn_press   = press;
   assign bus.cold_reset_ = cold_q;
   assign bus.warm_reset_ = warm_q;
   assign bus.por_done    = por_done_q;

endmodule
